// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
package vga_timing_pkg;

  // Standard 640x480 @ 60 Hz segment lengths (pixels / lines).
  localparam int unsigned VGA_640x480_60_H_ACTIVE = 640;
  localparam int unsigned VGA_640x480_60_H_FP     = 16;
  localparam int unsigned VGA_640x480_60_H_SYNC   = 96;
  localparam int unsigned VGA_640x480_60_H_BP     = 48;
  localparam int unsigned VGA_640x480_60_V_ACTIVE = 480;
  localparam int unsigned VGA_640x480_60_V_FP     = 10;
  localparam int unsigned VGA_640x480_60_V_SYNC   = 2;
  localparam int unsigned VGA_640x480_60_V_BP     = 33;

  // Sync pulse active level.
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Total period of one axis from its four segments.
  function automatic int unsigned total(input int unsigned a, input int unsigned fp,
                                        input int unsigned s, input int unsigned bp);
    return a + fp + s + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request / VGA output bundle between the timing generator and its neighbours.
interface vga_timing_gen_if #(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned CNT_W   = 11
);
  logic               en;
  logic [COLOR_W-1:0] pixel_r;
  logic [COLOR_W-1:0] pixel_g;
  logic [COLOR_W-1:0] pixel_b;
  logic [CNT_W-1:0]   xpos;
  logic [CNT_W-1:0]   ypos;
  logic               ptick;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               active;
  logic               line_start;
  logic               frame_start;

  // Timing generator side.
  modport master (
    input  en, pixel_r, pixel_g, pixel_b,
    output xpos, ypos, ptick, hsync, vsync, red, green, blue, active, line_start, frame_start
  );

  // Frame-buffer reader / DAC side.
  modport slave (
    output en, pixel_r, pixel_g, pixel_b,
    input  xpos, ypos, ptick, hsync, vsync, red, green, blue, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter: counts 0..i_last on i_inc, synchronous clear has priority.
module vga_axis_counter #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_end
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: wrap to zero after the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_end ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_end = (r_cnt == i_last);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered pixel/sync output stage.
// xpos/ypos lead the registered outputs by one pixel tick so the upstream reader
// can return the colour for that coordinate on the ptick clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned H_ACTIVE = VGA_640x480_60_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_640x480_60_H_FP,
  parameter int unsigned H_SYNC   = VGA_640x480_60_H_SYNC,
  parameter int unsigned H_BP     = VGA_640x480_60_H_BP,
  parameter int unsigned V_ACTIVE = VGA_640x480_60_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_640x480_60_V_FP,
  parameter int unsigned V_SYNC   = VGA_640x480_60_V_SYNC,
  parameter int unsigned V_BP     = VGA_640x480_60_V_BP,
  parameter logic        HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic        VS_POL   = SYNC_ACTIVE_LOW
) (
  input logic               clk,
  input logic               reset,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   r_div;
  logic               w_ptick;
  logic               w_clr;
  logic [CNT_W-1:0]   w_hcnt;
  logic [CNT_W-1:0]   w_vcnt;
  logic               w_h_end;
  logic               w_v_end;
  logic               w_v_inc;

  logic               w_act_n;
  logic               w_hs_n;
  logic               w_vs_n;
  logic               w_line_start_n;
  logic               w_frame_start_n;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_active;
  logic               r_line_start;
  logic               r_frame_start;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  // With CLK_DIV=1 the divider is stuck at 0 == DIV_LAST, so ptick stays high.
  assign w_ptick = (r_div == DIV_LAST);
  assign w_clr   = ~bus.en;
  assign w_v_inc = w_ptick & w_h_end;

  // Pixel clock divider; en low parks it at zero like reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_clr || w_ptick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  vga_axis_counter #(
    .CNT_W (CNT_W)
  ) u_hcnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_ptick),
    .i_last (H_LAST),
    .o_cnt  (w_hcnt),
    .o_end  (w_h_end)
  );

  vga_axis_counter #(
    .CNT_W (CNT_W)
  ) u_vcnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_v_inc),
    .i_last (V_LAST),
    .o_cnt  (w_vcnt),
    .o_end  (w_v_end)
  );

  // Output-stage values for the coordinate currently on xpos/ypos.
  always_comb begin
    w_act_n         = (w_hcnt < H_ACT) && (w_vcnt < V_ACT);
    w_hs_n          = ((w_hcnt >= HS_START) && (w_hcnt < HS_END)) ? HS_POL : ~HS_POL;
    w_vs_n          = ((w_vcnt >= VS_START) && (w_vcnt < VS_END)) ? VS_POL : ~VS_POL;
    w_line_start_n  = (w_hcnt == '0);
    w_frame_start_n = w_line_start_n && (w_vcnt == '0);
  end

  // Registered output stage: captures on ptick, holds between ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
    end else if (w_clr) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
    end else if (w_ptick) begin
      r_hsync       <= w_hs_n;
      r_vsync       <= w_vs_n;
      r_active      <= w_act_n;
      r_line_start  <= w_line_start_n;
      r_frame_start <= w_frame_start_n;
      r_red         <= w_act_n ? bus.pixel_r : '0;
      r_green       <= w_act_n ? bus.pixel_g : '0;
      r_blue        <= w_act_n ? bus.pixel_b : '0;
    end
  end

  // End of the last line must bring the vertical counter back to the top.
  a_frame_wrap: assert property (@(posedge clk) disable iff (reset)
    (w_v_inc && w_v_end) |=> (w_vcnt == '0));

  assign bus.xpos        = w_hcnt;
  assign bus.ypos        = w_vcnt;
  assign bus.ptick       = w_ptick;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.active      = r_active;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.red         = r_red;
  assign bus.green       = r_green;
  assign bus.blue        = r_blue;

endmodule
